sic1_serial_loader: RTL and testbench



---
 rtl/sic1_loader_pkg.sv | 23 ++
 rtl/sic1_uart_rx.sv | 110 +++++++++++
 rtl/sic1_serial_loader.sv | 185 ++++++++++++++++++
 tb/tb_sic1_serial_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sic1_loader_pkg.sv
// Shared constants and state types for the SIC-1 serial loader.
package sic1_loader_pkg;

  localparam logic [7:0] CMD_PC   = 8'h50;
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_HALT = 8'h48;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_LEN,
    GET_DATA
  } parser_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/sic1_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, start-glitch
// rejection and framing check. Emits one-cycle byte_valid / frame_err pulses.
module sic1_uart_rx
  import sic1_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  rx_state_t     r_state;
  rx_state_t     w_state_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_byte_valid;
  logic          r_frame_err;
  logic          w_fall;
  logic          w_tick_half;
  logic          w_tick_full;

  assign w_fall      = r_prev & ~r_sync2;
  assign w_tick_half = (r_cnt == HALF_M1);
  assign w_tick_full = (r_cnt == FULL_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RX_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RX_IDLE:  if (w_fall) w_state_next = RX_START;
      // Line back high at half a bit means a glitch, not a start bit.
      RX_START: if (w_tick_half) w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tick_full && (r_bit == 3'd7)) w_state_next = RX_STOP;
      RX_STOP:  if (w_tick_full) w_state_next = RX_IDLE;
      default:  w_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          r_bit <= '0;
        end
        RX_START: r_cnt <= w_tick_half ? '0 : r_cnt + 1'b1;
        RX_DATA: begin
          if (w_tick_full) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_tick_full) begin
            r_cnt        <= '0;
            r_byte_valid <= r_sync2;
            r_frame_err  <= ~r_sync2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/sic1_serial_loader.sv
// UART-driven halt-mode loader for the SIC-1 core: command parser, halt
// timer and registered set_pc/set_data strobes.
module sic1_serial_loader
  import sic1_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned HALT_WAIT    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] load_data,
  output logic       set_pc,
  output logic       set_data,
  output logic       run,
  output logic       busy,
  output logic       err
);

  localparam int unsigned HW = $clog2(HALT_WAIT + 1);

  logic [7:0]    w_byte;
  logic          w_byte_valid;
  logic          w_frame_err;

  parser_state_t r_state;
  parser_state_t w_state_next;
  logic [8:0]    r_count;
  logic [8:0]    w_count_next;
  logic [HW-1:0] r_halt;
  logic          r_run;
  logic          w_run_next;
  logic          r_err;
  logic          w_err_next;
  logic          r_pending;
  logic          r_pend_pc;
  logic [7:0]    r_pend_byte;
  logic          w_pend_next;
  logic          w_pend_pc_next;
  logic [7:0]    w_pend_byte_next;
  logic          w_start_halt;
  logic          w_take;
  logic          w_take_pc;
  logic          w_halt_done;
  logic          w_fire;
  logic          w_fire_pc;
  logic [7:0]    w_fire_byte;
  logic [7:0]    r_load_data;
  logic          r_set_pc;
  logic          r_set_data;
  logic          r_busy;

  sic1_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  assign w_halt_done = (r_halt == '0);

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_run_next   = r_run;
    w_err_next   = r_err;
    w_start_halt = 1'b0;
    w_take       = 1'b0;
    w_take_pc    = 1'b0;
    if (w_frame_err) begin
      w_state_next = IDLE;
      w_err_next   = 1'b1;
    end else if (w_byte_valid) begin
      case (r_state)
        IDLE: begin
          case (w_byte)
            CMD_PC: begin
              w_state_next = GET_ADDR;
              w_start_halt = 1'b1;
              w_run_next   = 1'b0;
              w_err_next   = 1'b0;
            end
            CMD_LOAD: begin
              w_state_next = GET_LEN;
              w_start_halt = 1'b1;
              w_run_next   = 1'b0;
              w_err_next   = 1'b0;
            end
            CMD_RUN: begin
              w_run_next = 1'b1;
              w_err_next = 1'b0;
            end
            CMD_HALT: begin
              w_run_next = 1'b0;
              w_err_next = 1'b0;
            end
            default: w_err_next = 1'b1;
          endcase
        end
        GET_ADDR: begin
          w_take       = 1'b1;
          w_take_pc    = 1'b1;
          w_state_next = IDLE;
        end
        GET_LEN: begin
          w_count_next = (w_byte == 8'd0) ? 9'd256 : {1'b0, w_byte};
          w_state_next = GET_DATA;
        end
        GET_DATA: begin
          w_take       = 1'b1;
          w_count_next = r_count - 9'd1;
          if (r_count == 9'd1) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // A byte fires straight away if the halt timer has expired, otherwise it
  // waits in the single pending slot until expiry.
  always_comb begin
    w_fire           = 1'b0;
    w_fire_pc        = r_pend_pc;
    w_fire_byte      = r_pend_byte;
    w_pend_next      = r_pending;
    w_pend_pc_next   = r_pend_pc;
    w_pend_byte_next = r_pend_byte;
    if (r_pending && w_halt_done) begin
      w_fire      = 1'b1;
      w_pend_next = 1'b0;
    end else if (w_take && w_halt_done) begin
      w_fire      = 1'b1;
      w_fire_pc   = w_take_pc;
      w_fire_byte = w_byte;
    end
    if (w_take && (r_pending || !w_halt_done)) begin
      w_pend_next      = 1'b1;
      w_pend_pc_next   = w_take_pc;
      w_pend_byte_next = w_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_halt      <= '0;
      r_run       <= 1'b0;
      r_err       <= 1'b0;
      r_pending   <= 1'b0;
      r_pend_pc   <= 1'b0;
      r_pend_byte <= '0;
      r_load_data <= '0;
      r_set_pc    <= 1'b0;
      r_set_data  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_run       <= w_run_next;
      r_err       <= w_err_next;
      r_pending   <= w_pend_next;
      r_pend_pc   <= w_pend_pc_next;
      r_pend_byte <= w_pend_byte_next;
      r_set_pc    <= w_fire & w_fire_pc;
      r_set_data  <= w_fire & ~w_fire_pc;
      if (w_fire) r_load_data <= w_fire_byte;
      r_busy      <= (w_state_next != IDLE) | w_pend_next | w_fire;
      if (w_start_halt)      r_halt <= HW'(HALT_WAIT);
      else if (!w_halt_done) r_halt <= r_halt - 1'b1;
    end
  end

  assign load_data = r_load_data;
  assign set_pc    = r_set_pc;
  assign set_data  = r_set_data;
  assign run       = r_run;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_sic1_serial_loader.sv
// Scoreboard bench for sic1_serial_loader: command-level model pushes
// expected strobes, a negedge monitor pops and compares them.
module tb_sic1_serial_loader;

  localparam int unsigned CPB = 16;
  localparam int unsigned HW  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] load_data;
  logic       set_pc;
  logic       set_data;
  logic       run;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  sic1_serial_loader #(
    .CLKS_PER_BIT(CPB),
    .HALT_WAIT   (HW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .load_data(load_data),
    .set_pc   (set_pc),
    .set_data (set_data),
    .run      (run),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    bit          is_pc;
    logic [7:0]  data;
    int unsigned min_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_stop_cyc = 0;
  bit          mon_en = 1'b0;
  bit          watch_run = 1'b0;
  bit          prev_strobe = 1'b0;
  bit          exp_run = 1'b0;
  bit          exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (set_pc || set_data) begin
        exp_t e;
        checks++;
        if (set_pc && set_data) begin
          errors++;
          $display("FAIL strobe_excl: set_pc=%0b set_data=%0b required one-hot", set_pc, set_data);
        end else if (prev_strobe) begin
          errors++;
          $display("FAIL strobe_width: strobe high for 2 cycles at cyc %0d, required 1", cyc);
        end else if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe: set_pc=%0b set_data=%0b data=%02h, required none",
                   set_pc, set_data, load_data);
        end else begin
          e = sb.pop_front();
          if (set_pc !== e.is_pc || load_data !== e.data || cyc < e.min_cyc) begin
            errors++;
            $display("FAIL strobe: got pc=%0b data=%02h cyc=%0d, required pc=%0b data=%02h cyc>=%0d",
                     set_pc, load_data, cyc, e.is_pc, e.data, e.min_cyc);
          end
        end
      end
      prev_strobe = set_pc | set_data;
      if (watch_run) begin
        checks++;
        if (run !== 1'b1) begin
          errors++;
          $display("FAIL run_glitch: run=%0b at cyc %0d, required 1", run, cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_ok;
    last_stop_cyc = cyc;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat ($urandom_range(2, 8)) @(negedge clk);
  endtask

  task automatic cmd_run();
    send_byte(8'h52, 1'b1);
    exp_run = 1'b1;
    exp_err = 1'b0;
    check("run_after_R", run, exp_run);
    check("err_after_R", err, exp_err);
  endtask

  task automatic cmd_halt();
    send_byte(8'h48, 1'b1);
    exp_run = 1'b0;
    exp_err = 1'b0;
    check("run_after_H", run, exp_run);
    check("err_after_H", err, exp_err);
  endtask

  task automatic cmd_pc(input logic [7:0] a);
    exp_t e;
    send_byte(8'h50, 1'b1);
    exp_run = 1'b0;
    exp_err = 1'b0;
    check("run_after_P", run, 0);
    check("busy_after_P", busy, 1);
    e.is_pc = 1'b1;
    e.data = a;
    e.min_cyc = last_stop_cyc + HW;
    sb.push_back(e);
    send_byte(a, 1'b1);
    check("busy_after_addr", busy, 0);
    check("run_after_addr", run, 0);
  endtask

  task automatic cmd_load(input logic [7:0] payload[$]);
    exp_t        e;
    int unsigned tmin;
    send_byte(8'h4C, 1'b1);
    exp_run = 1'b0;
    exp_err = 1'b0;
    tmin = last_stop_cyc + HW;
    check("run_after_L", run, 0);
    check("busy_after_L", busy, 1);
    send_byte(8'(payload.size()), 1'b1);
    foreach (payload[i]) begin
      e.is_pc = 1'b0;
      e.data = payload[i];
      e.min_cyc = tmin;
      sb.push_back(e);
      send_byte(payload[i], 1'b1);
    end
    check("busy_after_load", busy, 0);
    check("run_after_load", run, 0);
  endtask

  task automatic cmd_bad();
    logic [7:0] b;
    do b = 8'($urandom); while (b inside {8'h50, 8'h4C, 8'h52, 8'h48});
    send_byte(b, 1'b1);
    exp_err = 1'b1;
    check("err_after_bad", err, 1);
    check("busy_after_bad", busy, 0);
    check("run_after_bad", run, exp_run);
  endtask

  initial begin
    logic [7:0] pl[$];
    int unsigned waited;

    // Reset held with rx toggling
    repeat (40) begin
      @(negedge clk);
      rx = 1'($urandom);
    end
    check("rst_outputs", {load_data, set_pc, set_data, run, busy, err}, 0);
    rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    repeat (200) @(negedge clk);
    check("post_rst_outputs", {load_data, set_pc, set_data, run, busy, err}, 0);

    // PC set with core running
    cmd_run();
    cmd_pc(8'h10);

    // Three-byte load
    pl = '{8'hAA, 8'hBB, 8'hCC};
    cmd_load(pl);

    // Run / halt / repeated run without glitch
    cmd_run();
    cmd_halt();
    cmd_halt();
    cmd_run();
    watch_run = 1'b1;
    cmd_run();
    watch_run = 1'b0;

    // Framing error, unknown byte, then recovery
    send_byte(8'h50, 1'b0);
    exp_err = 1'b1;
    check("err_after_frame", err, 1);
    check("busy_after_frame", busy, 0);
    check("run_after_frame", run, 1);
    send_byte(8'h7F, 1'b1);
    check("err_after_7F", err, 1);
    cmd_run();

    // Short start glitch yields no byte
    rx = 1'b0;
    repeat (CPB / 2 - 3) @(negedge clk);
    rx = 1'b1;
    repeat (CPB * 12) @(negedge clk);
    check("glitch_err", err, 0);
    check("glitch_busy", busy, 0);
    check("glitch_run", run, 1);
    cmd_halt();

    // Reset in the middle of a load
    send_byte(8'h4C, 1'b1);
    send_byte(8'd5, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      e.is_pc = 1'b0;
      e.data = 8'(8'h30 + i);
      e.min_cyc = 0;
      sb.push_back(e);
      send_byte(e.data, 1'b1);
    end
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    exp_run = 1'b0;
    exp_err = 1'b0;
    repeat (300) @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_run", run, 0);
    check("midrst_err", err, 0);
    cmd_pc(8'hE7);

    // Randomised command stream
    repeat (12) begin
      case ($urandom_range(0, 4))
        0: cmd_run();
        1: cmd_halt();
        2: cmd_pc(8'($urandom));
        3: begin
          pl.delete();
          repeat ($urandom_range(1, 4)) pl.push_back(8'($urandom));
          cmd_load(pl);
        end
        default: cmd_bad();
      endcase
      check("rand_run", run, exp_run);
      check("rand_err", err, exp_err);
    end

    // Length 0 loads 256 bytes
    pl.delete();
    for (int i = 0; i < 256; i++) pl.push_back(8'(i));
    cmd_load(pl);

    waited = 0;
    while (sb.size() != 0 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
